// File: rtl/fp_sqrt_pkg.sv
// Shared types and elaboration helpers for the multi-bit unsigned square-root core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    // Number of BUSY step edges needed to retire all DATA_WIDTH/2 root bits.
    function automatic int iterations(input int data_width, input int bits_per_cycle);
        return data_width / (2 * bits_per_cycle);
    endfunction

    // Legal configurations: even width >= 4, 1/2/4 bits per cycle dividing the root width.
    function automatic bit params_legal(input int data_width, input int bits_per_cycle);
        return (data_width >= 4) && ((data_width % 2) == 0) &&
               ((bits_per_cycle == 1) || (bits_per_cycle == 2) || (bits_per_cycle == 4)) &&
               (((data_width / 2) % bits_per_cycle) == 0);
    endfunction

    // Counter width able to hold the iteration count itself.
    function automatic int cnt_width(input int data_width, input int bits_per_cycle);
        return $clog2(iterations(data_width, bits_per_cycle) + 1);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One radix-2 restoring square-root step: appends two radicand bits and retires one root bit.
// Latency: purely combinational.
// Backpressure: none; chained by the caller, which owns all flow control.
module sqrt_step #(
    parameter int RW = 28
) (
    input  logic [RW+1:0] rem_i,
    input  logic [RW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [RW+1:0] rem_o,
    output logic [RW-1:0] root_o
);

    logic [RW+1:0] rem_sh;
    logic [RW+2:0] trial;
    logic          trial_ge;
    logic          unused_top;

    // The incoming remainder never exceeds 2*root, and the root never fills its top bit
    // before the last step, so the bits shifted out here are always zero.
    assign unused_top = ^{rem_i[RW+1:RW], root_i[RW-1]};

    assign rem_sh   = {rem_i[RW-1:0], bits_i};
    assign trial    = {1'b0, rem_sh} - {1'b0, root_i, 2'b01};
    assign trial_ge = ~trial[RW+2];

    assign rem_o  = trial_ge ? trial[RW+1:0] : rem_sh;
    assign root_o = {root_i[RW-2:0], trial_ge};

endmodule

// File: rtl/unsigned_sqrt_multibit.sv
// Iterative unsigned integer sqrt, BITS_PER_CYCLE root bits per cycle, with tag and inexact flag.
// Latency: done pulses N+1 cycles after the start cycle, N = DATA_WIDTH/(2*BITS_PER_CYCLE).
// Backpressure: ready is low while BUSY; start is ignored then and must be held by the caller.
module unsigned_sqrt_multibit
    import fp_sqrt_pkg::*;
#(
    parameter int DATA_WIDTH     = 56,
    parameter int BITS_PER_CYCLE = 2,
    parameter int TAG_WIDTH      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   radicand,
    input  logic [TAG_WIDTH-1:0]    tag_in,
    input  logic                    abort,
    output logic                    ready,
    output logic                    done,
    output logic [DATA_WIDTH/2-1:0] result,
    output logic [DATA_WIDTH/2:0]   remainder,
    output logic                    inexact,
    output logic [TAG_WIDTH-1:0]    tag_out
);

    localparam int RW   = DATA_WIDTH / 2;
    localparam int REMW = RW + 2;
    localparam int N    = iterations(DATA_WIDTH, BITS_PER_CYCLE);
    localparam int CW   = cnt_width(DATA_WIDTH, BITS_PER_CYCLE);
    localparam int SHW  = 2 * BITS_PER_CYCLE;

    if (!params_legal(DATA_WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
        $error("unsigned_sqrt_multibit: unsupported DATA_WIDTH / BITS_PER_CYCLE combination");
    end

    sqrt_state_t            state_q;
    logic [CW-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]  sh_q;
    logic [DATA_WIDTH-1:0]  sh_d;
    logic [REMW-1:0]        rem_q;
    logic [REMW-1:0]        rem_d;
    logic [RW-1:0]          root_q;
    logic [RW-1:0]          root_d;
    logic [TAG_WIDTH-1:0]   tag_q;

    logic [RW-1:0]          result_q;
    logic [RW:0]            remainder_q;
    logic                   inexact_q;
    logic [TAG_WIDTH-1:0]   tag_out_q;

    logic [REMW-1:0]        rem_c  [BITS_PER_CYCLE+1];
    logic [RW-1:0]          root_c [BITS_PER_CYCLE+1];

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    // Chain of restoring steps; step g consumes radicand bit pair g from the top of the shifter.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        sqrt_step #(
            .RW (RW)
        ) u_step (
            .rem_i  (rem_c[g]),
            .root_i (root_c[g]),
            .bits_i (sh_q[DATA_WIDTH-1-2*g -: 2]),
            .rem_o  (rem_c[g+1]),
            .root_o (root_c[g+1])
        );
    end

    assign rem_d  = rem_c[BITS_PER_CYCLE];
    assign root_d = root_c[BITS_PER_CYCLE];
    assign sh_d   = sh_q << SHW;

    // FSM, iteration datapath and result registers; abort cancels and clears the visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            tag_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            inexact_q   <= 1'b0;
            tag_out_q   <= '0;
        end else begin
            case (state_q)
                BUSY: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        result_q    <= '0;
                        remainder_q <= '0;
                        inexact_q   <= 1'b0;
                        tag_out_q   <= '0;
                    end else begin
                        sh_q   <= sh_d;
                        rem_q  <= rem_d;
                        root_q <= root_d;
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q     <= DONE;
                            result_q    <= root_d;
                            remainder_q <= rem_d[RW:0];
                            inexact_q   <= |rem_d;
                            tag_out_q   <= tag_q;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state_q <= BUSY;
                        sh_q    <= radicand;
                        rem_q   <= '0;
                        root_q  <= '0;
                        tag_q   <= tag_in;
                        cnt_q   <= CW'(N);
                    end else begin
                        state_q <= IDLE;
                    end
                    if (abort && (state_q == DONE)) begin
                        result_q    <= '0;
                        remainder_q <= '0;
                        inexact_q   <= 1'b0;
                        tag_out_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q != BUSY);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign remainder = remainder_q;
    assign inexact   = inexact_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_unsigned_sqrt_multibit.sv
// Directed and randomised bench for unsigned_sqrt_multibit across several configurations.
// Latency: checks exact done timing per configuration.
// Backpressure: exercises held start, abort and asynchronous reset mid-operation.
module tb_unsigned_sqrt_multibit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // DATA_WIDTH=8, BITS_PER_CYCLE=2 instance (N=2)
    logic       a_start, a_abort;
    logic [7:0] a_rad;
    logic [2:0] a_tag_i, a_tag_o;
    logic       a_ready, a_done, a_inexact;
    logic [3:0] a_result;
    logic [4:0] a_rem;

    // default instance (N=14)
    logic        d_start, d_abort;
    logic [55:0] d_rad;
    logic [2:0]  d_tag_i, d_tag_o;
    logic        d_ready, d_done, d_inexact;
    logic [27:0] d_result;
    logic [28:0] d_rem;

    // DATA_WIDTH=16 instances with BITS_PER_CYCLE 1, 2, 4 sharing inputs
    logic        r_start;
    logic [15:0] r_rad;
    logic        r_ready   [3];
    logic        r_done    [3];
    logic        r_inexact [3];
    logic [7:0]  r_result  [3];
    logic [8:0]  r_rem     [3];
    logic [2:0]  r_tag     [3];

    unsigned_sqrt_multibit #(.DATA_WIDTH(8), .BITS_PER_CYCLE(2), .TAG_WIDTH(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .radicand(a_rad), .tag_in(a_tag_i),
        .abort(a_abort), .ready(a_ready), .done(a_done), .result(a_result),
        .remainder(a_rem), .inexact(a_inexact), .tag_out(a_tag_o));

    unsigned_sqrt_multibit u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .radicand(d_rad), .tag_in(d_tag_i),
        .abort(d_abort), .ready(d_ready), .done(d_done), .result(d_result),
        .remainder(d_rem), .inexact(d_inexact), .tag_out(d_tag_o));

    unsigned_sqrt_multibit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1), .TAG_WIDTH(3)) u_r1 (
        .clk(clk), .rst_n(rst_n), .start(r_start), .radicand(r_rad), .tag_in(3'd0),
        .abort(1'b0), .ready(r_ready[0]), .done(r_done[0]), .result(r_result[0]),
        .remainder(r_rem[0]), .inexact(r_inexact[0]), .tag_out(r_tag[0]));

    unsigned_sqrt_multibit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(2), .TAG_WIDTH(3)) u_r2 (
        .clk(clk), .rst_n(rst_n), .start(r_start), .radicand(r_rad), .tag_in(3'd0),
        .abort(1'b0), .ready(r_ready[1]), .done(r_done[1]), .result(r_result[1]),
        .remainder(r_rem[1]), .inexact(r_inexact[1]), .tag_out(r_tag[1]));

    unsigned_sqrt_multibit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4), .TAG_WIDTH(3)) u_r4 (
        .clk(clk), .rst_n(rst_n), .start(r_start), .radicand(r_rad), .tag_in(3'd0),
        .abort(1'b0), .ready(r_ready[2]), .done(r_done[2]), .result(r_result[2]),
        .remainder(r_rem[2]), .inexact(r_inexact[2]), .tag_out(r_tag[2]));

    // Reference: largest r with r*r <= x, built greedily from the top bit.
    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r, t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Present start for one cycle, then wait (bounded) for done; cyc counts cycles from start.
    task automatic op8(input logic [7:0] rad, input logic [2:0] tg, output int cyc);
        a_rad   = rad;
        a_tag_i = tg;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        cyc = 1;
        while (a_done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
    endtask

    task automatic chk8(input string nm, input int r, input int m, input int ix, input int tg);
        chk({nm, "_result"}, a_result, r);
        chk({nm, "_rem"}, a_rem, m);
        chk({nm, "_inexact"}, a_inexact, ix);
        chk({nm, "_tag"}, a_tag_o, tg);
    endtask

    initial begin
        int              cyc;
        logic            seen;
        longint unsigned exp_root, exp_rem;

        rst_n   = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_rad = '0; a_tag_i = '0;
        d_start = 1'b0; d_abort = 1'b0; d_rad = '0; d_tag_i = '0;
        r_start = 1'b0; r_rad = '0;

        // Reset state
        repeat (3) tick;
        chk("rst_ready", a_ready, 1);
        chk("rst_done", a_done, 0);
        chk("rst_result", a_result, 0);
        chk("rst_rem", a_rem, 0);
        chk("rst_inexact", a_inexact, 0);
        chk("rst_tag", a_tag_o, 0);
        chk("rst_d_ready", d_ready, 1);
        chk("rst_d_result", d_result, 0);
        rst_n = 1'b1;
        tick;

        // 200 -> 14 r4, with exact step timing
        a_rad = 8'd200; a_tag_i = 3'd1; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        chk("lat_busy_ready", a_ready, 0);
        chk("lat_busy_done0", a_done, 0);
        tick;
        chk("lat_busy_done1", a_done, 0);
        tick;
        chk("lat_done", a_done, 1);
        chk8("r200", 14, 4, 1, 1);
        tick;
        chk("pulse_one_cycle", a_done, 0);
        chk("hold_result", a_result, 14);

        op8(8'd144, 3'd2, cyc);
        chk("lat144", cyc, 3);
        chk8("r144", 12, 0, 0, 2);
        op8(8'd255, 3'd3, cyc);
        chk8("r255", 15, 30, 1, 3);
        op8(8'd0, 3'd4, cyc);
        chk("lat0", cyc, 3);
        chk8("r0", 0, 0, 0, 4);
        tick;

        // Full-width default configuration
        d_rad = 56'hFF_FFFF_FFFF_FFFF; d_tag_i = 3'd5; d_start = 1'b1;
        tick;
        d_start = 1'b0;
        cyc = 1;
        while (d_done !== 1'b1 && cyc < 60) begin
            tick;
            cyc++;
        end
        chk("def_latency", cyc, 15);
        chk("def_result", d_result, 64'h0FFF_FFFF);
        chk("def_rem", d_rem, 64'h1FFF_FFFE);
        chk("def_inexact", d_inexact, 1);
        chk("def_tag", d_tag_o, 5);
        tick;

        // Back-to-back with start held: accepts every N+1 cycles, BUSY starts ignored
        a_start = 1'b1; a_tag_i = 3'd0; a_rad = 8'd3;
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("b2b_done", a_done, (k % 3) == 2);
            chk("b2b_ready", a_ready, (k % 3) == 2);
            if ((k % 3) == 2) begin
                chk("b2b_tag", a_tag_o, (k - 2) % 8);
                chk("b2b_result", a_result, isqrt(64'((k - 2) * 17 + 3)));
            end
            a_tag_i = 3'((k + 1) % 8);
            a_rad   = 8'((k + 1) * 17 + 3);
        end
        a_start = 1'b0;
        tick;
        chk("b2b_idle_ready", a_ready, 1);
        chk("b2b_idle_done", a_done, 0);

        // Abort during BUSY together with start
        a_rad = 8'd100; a_tag_i = 3'd2; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        tick;
        chk("abort_pre_ready", a_ready, 0);
        a_abort = 1'b1; a_start = 1'b1; a_rad = 8'd49;
        tick;
        a_abort = 1'b0; a_start = 1'b0;
        chk("abort_ready", a_ready, 1);
        chk("abort_done", a_done, 0);
        seen = 1'b0;
        repeat (6) begin
            tick;
            seen = seen | a_done;
        end
        chk("abort_no_done", seen, 0);
        op8(8'd81, 3'd4, cyc);
        chk("lat81", cyc, 3);
        chk8("r81", 9, 0, 0, 4);
        tick;

        // Asynchronous reset mid-BUSY
        a_rad = 8'd200; a_tag_i = 3'd7; a_start = 1'b1;
        d_rad = 56'd1000; d_tag_i = 3'd6; d_start = 1'b1;
        tick;
        a_start = 1'b0; d_start = 1'b0;
        tick;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", a_ready, 1);
        chk("arst_done", a_done, 0);
        chk("arst_result", a_result, 0);
        chk("arst_tag", a_tag_o, 0);
        chk("arst_d_ready", d_ready, 1);
        chk("arst_d_result", d_result, 0);
        chk("arst_d_rem", d_rem, 0);
        chk("arst_d_tag", d_tag_o, 0);
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick;
            seen = seen | a_done | d_done;
        end
        chk("arst_no_done", seen, 0);
        chk("arst_post_ready", a_ready, 1);

        // Randomised radicands for BITS_PER_CYCLE 1, 2, 4 (3 checks each)
        for (int i = 0; i < 3334; i++) begin
            r_rad    = (i == 0) ? 16'hFFFF : 16'($urandom);
            exp_root = isqrt(64'(r_rad));
            exp_rem  = 64'(r_rad) - exp_root * exp_root;
            r_start  = 1'b1;
            tick;
            r_start = 1'b0;
            repeat (8) tick;
            chk("rnd_done_bpc1", r_done[0], 1);
            for (int j = 0; j < 3; j++) begin
                chk("rnd_result", r_result[j], exp_root);
                chk("rnd_rem", r_rem[j], exp_rem);
                chk("rnd_inexact", r_inexact[j], exp_rem != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
